// File: rtl/inst_encoder.sv
// Encodes decode-stage control bundles into RV32I instruction words and queues
// them in a 2-entry in-order FIFO with valid/ready handshakes on both sides.
module inst_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  input  logic [2:0]  alu_op,
  input  logic        alu_src,
  input  logic        mem_to_reg,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] inst,
  output logic        illegal,
  output logic [15:0] enc_count
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic        illegal;
  } entry_t;

  localparam logic [31:0] NOP_INST  = 32'h0000_0013;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_REG    = 7'b0110011;
  localparam logic [2:0]  ALU_ADD   = 3'b000;
  localparam logic [2:0]  ALU_SUB   = 3'b001;
  localparam logic [2:0]  ALU_XOR   = 3'b010;
  localparam logic [2:0]  ALU_SRA   = 3'b011;
  localparam logic [2:0]  ALU_AND   = 3'b100;

  state_t      state_q, state_d;
  entry_t      fifo_mem [2];
  entry_t      enc;
  entry_t      head;
  logic        wr_ptr_q, rd_ptr_q;
  logic [15:0] count_q;
  logic        accept, pop;
  logic        ctrl_none;

  // Only imm[11:0] is encodable; the upper bits are deliberately dropped.
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm[31:12];

  assign in_ready  = !reset && (state_q != FULL);
  assign out_valid = !reset && (state_q != EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign ctrl_none = !(alu_src || mem_to_reg || reg_write || mem_read || mem_write);

  // First matching rule wins; anything that does not reach a legal encoding
  // leaves the illegal/NOP default in place.
  always_comb begin
    // NOTE: defaults first so every path assigns enc and no latch is inferred.
    enc.inst    = NOP_INST;
    enc.illegal = 1'b1;
    if (mem_read && mem_write) begin
      enc.illegal = 1'b1;
    end else if (mem_write) begin
      if (!reg_write && alu_src && alu_op == ALU_ADD) begin
        enc.inst    = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
        enc.illegal = 1'b0;
      end
    end else if (mem_read) begin
      if (reg_write && mem_to_reg && alu_src && alu_op == ALU_ADD) begin
        enc.inst    = {imm[11:0], rs1, 3'b010, rd, OP_LOAD};
        enc.illegal = 1'b0;
      end
    end else if (reg_write && alu_src && !mem_to_reg) begin
      case (alu_op)
        ALU_ADD: begin
          enc.inst    = {imm[11:0], rs1, 3'b000, rd, OP_IMM};
          enc.illegal = 1'b0;
        end
        ALU_AND: begin
          enc.inst    = {imm[11:0], rs1, 3'b111, rd, OP_IMM};
          enc.illegal = 1'b0;
        end
        default: ;
      endcase
    end else if (reg_write && !alu_src && !mem_to_reg) begin
      enc.illegal = 1'b0;
      case (alu_op)
        ALU_ADD: enc.inst = {7'b0000000, rs2, rs1, 3'b000, rd, OP_REG};
        ALU_SUB: enc.inst = {7'b0100000, rs2, rs1, 3'b000, rd, OP_REG};
        ALU_XOR: enc.inst = {7'b0000000, rs2, rs1, 3'b100, rd, OP_REG};
        ALU_SRA: enc.inst = {7'b0100000, rs2, rs1, 3'b101, rd, OP_REG};
        default: enc.illegal = 1'b1;
      endcase
    end else if (ctrl_none) begin
      enc.illegal = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = ONE;
      ONE: begin
        if (accept && !pop)      state_d = FULL;
        else if (!accept && pop) state_d = EMPTY;
      end
      FULL:  if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) wr_ptr_q <= ~wr_ptr_q;
      if (pop)    rd_ptr_q <= ~rd_ptr_q;
      if (accept && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
    end
  end

  // NOTE: FIFO storage is not reset; the outputs are masked by out_valid, so
  // stale entries are never visible and the RAM needs no reset path.
  always_ff @(posedge clk) begin
    if (accept) fifo_mem[wr_ptr_q] <= enc;
  end

  assign head      = fifo_mem[rd_ptr_q];
  assign inst      = out_valid ? head.inst : 32'h0;
  assign illegal   = out_valid && head.illegal;
  assign enc_count = reset ? 16'h0 : count_q;

endmodule
